swish: RTL and testbench

SWISH -- requirements
Module: swish

---
 rtl/swish_pkg.sv | 29 ++
 rtl/swish_div6.sv | 50 +++++
 rtl/swish.sv | 66 ++++++
 tb/tb_swish.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/swish_pkg.sv
// Shared constants and helpers for the hard-swish pipeline.
// Holds the ReLU6 clamp limits, the 1/6 reciprocal scaling and saturation.
package swish_pkg;

    localparam int RELU6_OFFSET = 3;
    localparam int RELU6_MAX    = 6;
    localparam int RECIP6_MUL   = 43;
    localparam int RECIP6_SHIFT = 8;
    localparam int RECIP6_RND   = 128;

    // Clamp v into the signed range of a width-bit integer.
    function automatic logic signed [31:0] sat_width(
        input logic signed [31:0] v,
        input int                 width
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/swish_div6.sv
// Combinational divide-by-6 with round-half-away-from-zero and saturation.
// Ports: p (product, WIDTH+4 signed) in, y (WIDTH signed) out.
module swish_div6 #(
    parameter int WIDTH         = 8,
    parameter int USE_SHIFT_ADD = 0
) (
    input  logic signed [WIDTH+3:0] p,
    output logic signed [WIDTH-1:0] y
);
    import swish_pkg::*;

    localparam int PW = WIDTH + 4;
    localparam int MW = WIDTH + 10;

    logic              neg;
    logic [PW-1:0]     mag;
    logic [MW-1:0]     mag_w;
    logic [MW-1:0]     q;
    logic signed [31:0] q_s;

    // Work on the magnitude so both modes round symmetrically about zero.
    always_comb begin
        neg   = p[PW-1];
        mag   = neg ? PW'(-p) : PW'(p);
        mag_w = {{(MW - PW){1'b0}}, mag};
    end

    generate
        if (USE_SHIFT_ADD != 0) begin : g_shift_add
            logic [MW-1:0] prod;
            // mag * 43 as 32 + 8 + 2 + 1, then scale by 1/256 with rounding.
            always_comb begin
                prod = (mag_w << 5) + (mag_w << 3)
                     + (mag_w << 1) + mag_w;
                q    = (prod + MW'(RECIP6_RND)) >> RECIP6_SHIFT;
            end
        end else begin : g_exact
            // Adding half the divisor before truncation rounds ties away.
            always_comb begin
                q = (mag_w + MW'(RELU6_OFFSET)) / MW'(RELU6_MAX);
            end
        end
    endgenerate

    always_comb begin
        q_s = neg ? -$signed(32'(q)) : $signed(32'(q));
        y   = WIDTH'(sat_width(q_s, WIDTH));
    end

endmodule

// File: rtl/swish.sv
// Two-stage hard-swish pipeline: y = x * clamp(x + 3, 0, 6) / 6.
// Ports: clk, rst_n, in_valid, x in; out_valid, y out (latency 2, II 1).
module swish #(
    parameter int WIDTH         = 8,
    parameter int USE_SHIFT_ADD = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] x,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] y
);
    import swish_pkg::*;

    localparam int XW = WIDTH + 1;
    localparam int PW = WIDTH + 4;

    logic signed [XW-1:0] xp3;
    logic [2:0]           r;
    logic signed [PW-1:0] p_next;
    logic                 v1;
    logic signed [PW-1:0] p1;
    logic signed [WIDTH-1:0] y_next;

    // One extra bit keeps x + 3 from wrapping at the top of the range.
    always_comb begin
        xp3 = XW'(x) + XW'(RELU6_OFFSET);
        if (xp3[XW-1]) begin
            r = 3'd0;
        end else if (xp3 > XW'(RELU6_MAX)) begin
            r = 3'(RELU6_MAX);
        end else begin
            r = xp3[2:0];
        end
        p_next = PW'(x) * PW'($signed({1'b0, r}));
    end

    swish_div6 #(
        .WIDTH        (WIDTH),
        .USE_SHIFT_ADD(USE_SHIFT_ADD)
    ) u_div6 (
        .p(p1),
        .y(y_next)
    );

    // Data registers only load on a valid beat so y holds through gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            p1        <= '0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                p1 <= p_next;
            end
            if (v1) begin
                y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_swish.sv
// Directed bench for swish: both scaling modes side by side.
// Sweeps, extremes, exhaustive range, valid gaps and mid-flight reset.
module tb_swish;

    localparam int W = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] x = '0;
    logic                ov0;
    logic                ov1;
    logic signed [W-1:0] y0;
    logic signed [W-1:0] y1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int qx[$];
    int qe0[$];
    int qe1[$];

    always #5 clk = ~clk;

    swish #(.WIDTH(W), .USE_SHIFT_ADD(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .x        (x),
        .out_valid(ov0),
        .y        (y0)
    );

    swish #(.WIDTH(W), .USE_SHIFT_ADD(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .x        (x),
        .out_valid(ov1),
        .y        (y1)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int relu6(input int xv);
        int r;
        r = xv + 3;
        if (r < 0) r = 0;
        if (r > 6) r = 6;
        return r;
    endfunction

    // Real-valued hard-swish, rounded half away from zero.
    function automatic int ref_real(input int xv);
        real h;
        int  q;
        h = real'(xv) * real'(relu6(xv)) / 6.0;
        if (h >= 0.0) q = int'($floor(h + 0.5));
        else q = -int'($floor(-h + 0.5));
        return sat8(q);
    endfunction

    function automatic int ref_sa(input int xv);
        int p;
        int m;
        int q;
        p = xv * relu6(xv);
        m = (p < 0) ? -p : p;
        q = (m * 43 + 128) / 256;
        return sat8((p < 0) ? -q : q);
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Stream qx back to back; each result must show up exactly two cycles later.
    task automatic stream(input string tag);
        int n;
        n = qx.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                in_valid = 1'b1;
                x = W'(qx[i]);
            end else begin
                in_valid = 1'b0;
                x = '0;
            end
            step();
            if (i == 0) begin
                chk({tag, "_early_ov0"}, {31'b0, ov0}, 0);
                chk({tag, "_early_ov1"}, {31'b0, ov1}, 0);
            end else begin
                chk({tag, "_ov0"}, {31'b0, ov0}, 1);
                chk({tag, "_ov1"}, {31'b0, ov1}, 1);
                chk({tag, "_y0"}, y0, qe0[i-1]);
                chk({tag, "_y1"}, y1, qe1[i-1]);
                chk({tag, "_tol"}, absdiff(int'(y1), qe0[i-1]) <= 1, 1);
            end
        end
    endtask

    int sweep_e[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    bit gap_v[5]    = '{1, 0, 1, 1, 0};
    int gap_x[5]    = '{6, 9, 7, 4, 0};

    initial begin
        int held;

        // Reset state.
        step();
        step();
        chk("rst_ov0", {31'b0, ov0}, 0);
        chk("rst_y0", y0, 0);
        chk("rst_ov1", {31'b0, ov1}, 0);
        chk("rst_y1", y1, 0);

        // First sample right after release.
        rst_n = 1'b1;
        in_valid = 1'b1;
        x = 8'sd5;
        step();
        chk("first_ov_early", {31'b0, ov0}, 0);
        in_valid = 1'b0;
        step();
        chk("first_ov0", {31'b0, ov0}, 1);
        chk("first_y0", y0, 5);
        chk("first_y1", y1, 5);

        // Sweep -8..8 against hand table.
        qx.delete(); qe0.delete(); qe1.delete();
        for (int v = -8; v <= 8; v++) begin
            qx.push_back(v);
            qe0.push_back(sweep_e[v + 8]);
            qe1.push_back(sweep_e[v + 8]);
        end
        stream("sweep");

        // Extremes; mode 1 raw value 128 saturates to 127.
        qx.delete(); qe0.delete(); qe1.delete();
        qx.push_back(-128); qe0.push_back(0);   qe1.push_back(0);
        qx.push_back(127);  qe0.push_back(127); qe1.push_back(127);
        stream("ext");

        // Exhaustive range.
        qx.delete(); qe0.delete(); qe1.delete();
        for (int v = -128; v <= 127; v++) begin
            qx.push_back(v);
            qe0.push_back(ref_real(v));
            qe1.push_back(ref_sa(v));
        end
        stream("exh");

        // Valid pattern 1,0,1,1: y must hold across the gap.
        held = 127;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                in_valid = gap_v[i];
                x = W'(gap_x[i]);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                if (gap_v[i-1]) held = gap_x[i-1];
                chk("gap_ov0", {31'b0, ov0}, {31'b0, gap_v[i-1]});
                chk("gap_ov1", {31'b0, ov1}, {31'b0, gap_v[i-1]});
                chk("gap_y0", y0, held);
                chk("gap_y1", y1, held);
            end
        end

        // Reset with two samples in flight.
        in_valid = 1'b1;
        x = 8'sd5;
        step();
        x = 8'sd6;
        step();
        chk("pre_rst_ov0", {31'b0, ov0}, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov0", {31'b0, ov0}, 0);
        chk("arst_y0", y0, 0);
        chk("arst_ov1", {31'b0, ov1}, 0);
        chk("arst_y1", y1, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_ov0", {31'b0, ov0}, 0);
            chk("post_rst_ov1", {31'b0, ov1}, 0);
            chk("post_rst_y0", y0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
